// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns a byte-stream command channel into register
// read/write strobes and streams read bytes back on a response channel.
module reg_bus_master #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREAD_LATENCY = 1
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,
  input  logic [7:0]               cmd_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [7:0]               rsp_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datai,
  input  logic [7:0]               reg_datao,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     busy,
  output logic                     txn_done,
  output logic                     cmd_error
);

  typedef enum logic [3:0] {
    CMD, ADDR, LEN_LO, LEN_HI, WR_DATA, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(pREAD_LATENCY - 1);

  state_t      state;
  logic        is_read;
  logic [7:0]  len_lo;
  logic [15:0] remaining;
  logic [15:0] counter;
  logic [1:0]  wait_cnt;
  logic        accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CMD;
      cmd_ready   <= 1'b0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      reg_address <= '0;
      reg_bytecnt <= '0;
      reg_datai   <= '0;
      reg_read    <= 1'b0;
      reg_write   <= 1'b0;
      busy        <= 1'b0;
      txn_done    <= 1'b0;
      cmd_error   <= 1'b0;
      is_read     <= 1'b0;
      len_lo      <= '0;
      remaining   <= '0;
      counter     <= '0;
      wait_cnt    <= '0;
    end else begin
      reg_write <= 1'b0;
      reg_read  <= 1'b0;
      txn_done  <= 1'b0;
      cmd_error <= 1'b0;
      case (state)
        CMD: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            if (cmd_data[6:0] != 7'd0) begin
              cmd_error <= 1'b1;
            end else begin
              is_read <= cmd_data[7];
              busy    <= 1'b1;
              state   <= ADDR;
            end
          end
        end
        ADDR: begin
          if (accept) begin
            reg_address <= cmd_data;
            state       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_lo    <= cmd_data;
            counter   <= '0;
            remaining <= '0;
            state     <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            counter   <= '0;
            remaining <= {cmd_data, len_lo};
            if ({cmd_data, len_lo} == 16'd0) begin
              cmd_ready <= 1'b0;
              txn_done  <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else if (is_read) begin
              cmd_ready   <= 1'b0;
              reg_read    <= 1'b1;
              reg_bytecnt <= '0;
              state       <= RD_ISSUE;
            end else begin
              state <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          // cmd_ready drops with the last byte so DONE lands after its strobe
          if (accept) begin
            reg_write   <= 1'b1;
            reg_datai   <= cmd_data;
            reg_bytecnt <= pBYTECNT_SIZE'(counter);
            counter     <= counter + 16'd1;
            remaining   <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              cmd_ready <= 1'b0;
            end
          end else if (!cmd_ready) begin
            txn_done <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        RD_ISSUE: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            rsp_data  <= reg_datao;
            rsp_valid <= 1'b1;
            state     <= RD_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RD_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            counter   <= counter + 16'd1;
            remaining <= remaining - 16'd1;
            if (remaining != 16'd1) begin
              reg_read    <= 1'b1;
              reg_bytecnt <= pBYTECNT_SIZE'(counter + 16'd1);
              state       <= RD_ISSUE;
            end else begin
              txn_done <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= CMD;
        end
        default: begin
          cmd_ready <= 1'b0;
          state     <= CMD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Randomized self-checking bench for reg_bus_master; a second instance with a
// 2-bit byte counter shares the command stream to observe bytecnt wrap.
module tb_reg_bus_master;
  localparam int RL  = 1;
  localparam int BW  = 7;
  localparam int BWW = 2;

  logic          clk_usb   = 1'b0;
  logic          reset_n   = 1'b1;
  logic [7:0]    cmd_data  = '0;
  logic          cmd_valid = 1'b0;
  logic          rsp_ready = 1'b1;
  logic [7:0]    reg_datao;
  logic          cmd_ready, rsp_valid, reg_read, reg_write, busy, txn_done, cmd_error;
  logic [7:0]    rsp_data, reg_address, reg_datai;
  logic [BW-1:0] reg_bytecnt;
  logic          w_cmd_ready, w_rsp_valid, w_reg_read, w_reg_write, w_busy, w_txn_done, w_cmd_error;
  logic [7:0]    w_rsp_data, w_reg_address, w_reg_datai;
  logic [BWW-1:0] w_reg_bytecnt;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit bp = 1'b0;

  always #5 clk_usb = ~clk_usb;
  always @(posedge clk_usb) cyc <= cyc + 1;

  reg_bus_master #(.pBYTECNT_SIZE(BW), .pREAD_LATENCY(RL)) dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai),
    .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write), .busy(busy),
    .txn_done(txn_done), .cmd_error(cmd_error));

  reg_bus_master #(.pBYTECNT_SIZE(BWW), .pREAD_LATENCY(RL)) dut_wrap (
    .clk_usb(clk_usb), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(w_cmd_ready), .rsp_data(w_rsp_data), .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
    .reg_address(w_reg_address), .reg_bytecnt(w_reg_bytecnt), .reg_datai(w_reg_datai),
    .reg_datao(reg_datao), .reg_read(w_reg_read), .reg_write(w_reg_write), .busy(w_busy),
    .txn_done(w_txn_done), .cmd_error(w_cmd_error));

  // Responder: data for a read strobe appears exactly RL cycles later.
  logic          rd_pipe [0:3] = '{default: 1'b0};
  logic [BW-1:0] bc_pipe [0:3] = '{default: '0};
  always @(posedge clk_usb) begin
    rd_pipe[0] <= reg_read;
    bc_pipe[0] <= reg_bytecnt;
    for (int i = 1; i < 4; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      bc_pipe[i] <= bc_pipe[i-1];
    end
  end
  assign reg_datao = rd_pipe[RL-1] ? (8'hA0 + {1'b0, bc_pipe[RL-1]}) : 8'h00;

  initial begin
    forever begin
      @(posedge clk_usb);
      #1;
      rsp_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  typedef struct { logic [7:0] addr; int bc; logic [7:0] data; int cyc; } wr_t;
  typedef struct { logic [7:0] addr; int bc; int cyc; } rd_t;
  typedef struct { logic [7:0] data; int cyc; } rs_t;
  wr_t wq[$];
  rd_t rq[$];
  rs_t sq[$];
  int  wbc_q[$];
  int  dq[$];
  int  hs_q[$];
  int  err_n = 0, both_n = 0, stab_n = 0;
  bit  stall = 1'b0;
  logic [7:0] held = '0;
  logic [7:0] wdata[$];

  always @(negedge clk_usb) begin
    if (reset_n) begin
      if (reg_write) wq.push_back('{reg_address, int'(reg_bytecnt), reg_datai, cyc});
      if (w_reg_write) wbc_q.push_back(int'(w_reg_bytecnt));
      if (reg_read) rq.push_back('{reg_address, int'(reg_bytecnt), cyc});
      if (reg_read && reg_write) both_n++;
      if (reg_read && rsp_valid) both_n++;
      if (txn_done) dq.push_back(cyc);
      if (cmd_error) err_n++;
      if (stall && (!rsp_valid || rsp_data !== held)) stab_n++;
      if (rsp_valid && rsp_ready) sq.push_back('{rsp_data, cyc});
      stall = rsp_valid && !rsp_ready;
      held  = rsp_data;
    end
  end

  task automatic clear_logs();
    wq.delete(); rq.delete(); sq.delete(); wbc_q.delete(); dq.delete(); hs_q.delete();
    err_n = 0; both_n = 0; stab_n = 0; stall = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the cycle following the handshake.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk_usb);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(negedge clk_usb);
    hs_q.push_back(cyc);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (dq.size() == 0 && n < budget) begin
      @(negedge clk_usb);
      n++;
    end
    ok = (dq.size() != 0);
    repeat (3) @(negedge clk_usb);
  endtask

  function automatic logic [37:0] all_outs();
    return {cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt, reg_datai,
            reg_read, reg_write, busy, txn_done, cmd_error};
  endfunction

  task automatic test_reset();
    #1 reset_n = 1'b0;
    @(negedge clk_usb);
    n_checks++;
    if (all_outs() !== '0) $display("FAIL reset_outputs: got %h, required 0", all_outs());
    else n_pass++;
    @(negedge clk_usb);
    reset_n = 1'b1;
    @(negedge clk_usb);
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_write(input logic [7:0] addr, input int gap_max, input string name);
    int len = wdata.size();
    bit ok;
    clear_logs();
    send_byte(8'h00); send_byte(addr); send_byte(8'(len)); send_byte(8'(len >> 8));
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk_usb);
      send_byte(wdata[i]);
    end
    wait_done(50 + 4 * len, ok);
    n_checks++;
    if (!ok || dq.size() != 1) $display("FAIL %s_done: txn_done pulses=%0d, required 1", name, dq.size());
    else n_pass++;
    n_checks++;
    if (wq.size() != len || wbc_q.size() != len)
      $display("FAIL %s_count: writes=%0d wrap_writes=%0d, required %0d", name, wq.size(), wbc_q.size(), len);
    else n_pass++;
    for (int i = 0; i < len && i < wq.size() && i < wbc_q.size(); i++) begin
      n_checks++;
      if (wq[i].addr !== addr || wq[i].bc != i % 128 || wq[i].data !== wdata[i])
        $display("FAIL %s_write[%0d]: addr=%h bc=%0d data=%h, required addr=%h bc=%0d data=%h",
                 name, i, wq[i].addr, wq[i].bc, wq[i].data, addr, i % 128, wdata[i]);
      else n_pass++;
      n_checks++;
      if (wbc_q[i] != i % 4) $display("FAIL %s_wrap_bc[%0d]: got %0d, required %0d", name, i, wbc_q[i], i % 4);
      else n_pass++;
      n_checks++;
      if (wq[i].cyc != hs_q[4+i]) $display("FAIL %s_wlat[%0d]: strobe cycle %0d, required %0d", name, i, wq[i].cyc, hs_q[4+i]);
      else n_pass++;
    end
    if (len > 0 && wq.size() == len && dq.size() > 0) begin
      n_checks++;
      if (dq[0] != wq[len-1].cyc + 1) $display("FAIL %s_done_cycle: got %0d, required %0d", name, dq[0], wq[len-1].cyc + 1);
      else n_pass++;
    end
    n_checks++;
    if (both_n != 0 || rq.size() != 0) $display("FAIL %s_no_read: overlaps=%0d reads=%0d, required 0", name, both_n, rq.size());
    else n_pass++;
  endtask

  task automatic test_read(input logic [7:0] addr, input int len, input bit use_bp, input string name);
    bit ok;
    clear_logs();
    bp = use_bp;
    send_byte(8'h80); send_byte(addr); send_byte(8'(len)); send_byte(8'(len >> 8));
    wait_done(100 + 40 * len, ok);
    bp = 1'b0;
    n_checks++;
    if (!ok || dq.size() != 1) $display("FAIL %s_done: txn_done pulses=%0d, required 1", name, dq.size());
    else n_pass++;
    n_checks++;
    if (sq.size() != len || rq.size() != len)
      $display("FAIL %s_count: rsp=%0d reads=%0d, required %0d", name, sq.size(), rq.size(), len);
    else n_pass++;
    for (int i = 0; i < len && i < sq.size() && i < rq.size(); i++) begin
      logic [7:0] exp;
      exp = 8'hA0 + 8'(i % 128);
      n_checks++;
      if (sq[i].data !== exp) $display("FAIL %s_rsp[%0d]: got %h, required %h", name, i, sq[i].data, exp);
      else n_pass++;
      n_checks++;
      if (rq[i].addr !== addr || rq[i].bc != i % 128)
        $display("FAIL %s_read[%0d]: addr=%h bc=%0d, required addr=%h bc=%0d", name, i, rq[i].addr, rq[i].bc, addr, i % 128);
      else n_pass++;
      if (!use_bp) begin
        n_checks++;
        if (rq[i].cyc != rq[0].cyc + i * (RL + 2))
          $display("FAIL %s_period[%0d]: cycle %0d, required %0d", name, i, rq[i].cyc, rq[0].cyc + i * (RL + 2));
        else n_pass++;
        n_checks++;
        if (sq[i].cyc != rq[i].cyc + RL + 1)
          $display("FAIL %s_rlat[%0d]: rsp cycle %0d, required %0d", name, i, sq[i].cyc, rq[i].cyc + RL + 1);
        else n_pass++;
      end
    end
    if (sq.size() == len && dq.size() > 0) begin
      n_checks++;
      if (dq[0] != sq[len-1].cyc + 1) $display("FAIL %s_done_cycle: got %0d, required %0d", name, dq[0], sq[len-1].cyc + 1);
      else n_pass++;
    end
    n_checks++;
    if (stab_n != 0 || both_n != 0 || wq.size() != 0)
      $display("FAIL %s_hold: unstable=%0d overlaps=%0d writes=%0d, required 0", name, stab_n, both_n, wq.size());
    else n_pass++;
  endtask

  task automatic test_error_zero();
    logic [7:0] bad [3] = '{8'h41, 8'h81, 8'h01};
    bit ok;
    clear_logs();
    for (int i = 0; i < 3; i++) send_byte(bad[i]);
    repeat (3) @(negedge clk_usb);
    n_checks++;
    if (err_n != 3 || busy !== 1'b0) $display("FAIL error_pulses: errors=%0d busy=%b, required 3 and 0", err_n, busy);
    else n_pass++;
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    wait_done(20, ok);
    n_checks++;
    if (!ok || dq.size() != 1) $display("FAIL zero_len_done: txn_done pulses=%0d, required 1", dq.size());
    else n_pass++;
    n_checks++;
    if (wq.size() != 0 || rq.size() != 0 || err_n != 3)
      $display("FAIL error_zero_strobes: writes=%0d reads=%0d errors=%0d, required 0 0 3", wq.size(), rq.size(), err_n);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0, b1, c0;
    bit ok;
    b0 = 8'($urandom); b1 = 8'($urandom); c0 = 8'($urandom);
    clear_logs();
    send_byte(8'h00); send_byte(8'h33); send_byte(8'h04); send_byte(8'h00);
    send_byte(b0); send_byte(b1);
    n_checks++;
    if (busy !== 1'b1 || reg_write !== 1'b1) $display("FAIL midrst_active: busy=%b reg_write=%b, required 1 1", busy, reg_write);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== '0) $display("FAIL midrst_async: got %h, required 0", all_outs());
    else n_pass++;
    repeat (2) @(negedge clk_usb);
    reset_n = 1'b1;
    send_byte(8'h00); send_byte(8'h44); send_byte(8'h01); send_byte(8'h00); send_byte(c0);
    wait_done(30, ok);
    n_checks++;
    if (!ok || dq.size() != 1) $display("FAIL midrst_done: txn_done pulses=%0d, required 1", dq.size());
    else n_pass++;
    n_checks++;
    if (wq.size() != 3) $display("FAIL midrst_count: writes=%0d, required 3", wq.size());
    else n_pass++;
    if (wq.size() == 3) begin
      n_checks++;
      if (wq[0].data !== b0 || wq[1].data !== b1 || wq[2].addr !== 8'h44 || wq[2].bc != 0 || wq[2].data !== c0)
        $display("FAIL midrst_writes: %h %h / addr=%h bc=%0d data=%h, required %h %h / addr=44 bc=0 data=%h",
                 wq[0].data, wq[1].data, wq[2].addr, wq[2].bc, wq[2].data, b0, b1, c0);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    wdata = '{8'h11, 8'h22, 8'h33};
    test_write(8'h2A, 0, "write");
    test_read(8'h05, 4, 1'b0, "read");
    test_read(8'h05, 4, 1'b1, "read_bp");
    test_error_zero();
    wdata.delete();
    for (int i = 0; i < 6; i++) wdata.push_back(8'($urandom));
    test_write(8'h3C, 0, "wrap");
    for (int t = 0; t < 4; t++) begin
      wdata.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) wdata.push_back(8'($urandom));
      test_write(8'($urandom), 2, "rand_write");
    end
    wdata.delete();
    for (int i = 0; i < 130; i++) wdata.push_back(8'($urandom));
    test_write(8'($urandom), 0, "long_write");
    for (int t = 0; t < 4; t++) test_read(8'($urandom), int'($urandom_range(1, 6)), 1'b1, "rand_read");
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
